// File: rtl/tea_cipher_engine.sv
// Iterative TEA encrypt/decrypt engine: ROUNDS/UNROLL clocks from accept to out_valid_o, result held until out_ready_i.
// Optional CBC chaining is enabled with `define TEA_CBC_EN; the default build is ECB only.
module tea_cipher_engine #(
  parameter int          ROUNDS = 32,
  parameter int          UNROLL = 1,
  parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic          mode_i,
  input  logic [127:0]  key_i,
  input  logic [63:0]   block_i,
  input  logic [63:0]   iv_i,
  input  logic          iv_load_i,
  input  logic          chain_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [63:0]   block_o,
  output logic          busy_o,
  output logic          int_o
);

  if ((UNROLL < 1) || (ROUNDS < 1) || ((ROUNDS % UNROLL) != 0)) begin : g_param_err
    $error("tea_cipher_engine: UNROLL must be >=1 and divide ROUNDS (>=1)");
  end

  localparam int          CW       = $clog2(ROUNDS + 1);
  localparam logic [63:0] SUM_PROD = {32'd0, DELTA} * 64'(ROUNDS);
  localparam logic [31:0] SUM_DEC  = SUM_PROD[31:0];

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state;
  logic [31:0]    v0_q, v1_q, sum_q;
  logic [127:0]   key_q;
  logic           mode_q;
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  cnt_nxt;
  logic           last;
  logic [31:0]    c0, c1, cs;
  logic [31:0]    k0, k1, k2, k3;
  logic [63:0]    blk_in;
  logic [63:0]    result;

  assign k0 = key_q[127:96];
  assign k1 = key_q[95:64];
  assign k2 = key_q[63:32];
  assign k3 = key_q[31:0];

  assign cnt_nxt = cnt_q + CW'(UNROLL);
  assign last    = (cnt_nxt == CW'(ROUNDS));

  always_comb begin
    c0 = v0_q;
    c1 = v1_q;
    cs = sum_q;
    for (int i = 0; i < UNROLL; i++) begin
      if (!mode_q) begin
        cs = cs + DELTA;
        c0 = c0 + (((c1 << 4) + k0) ^ (c1 + cs) ^ ((c1 >> 5) + k1));
        c1 = c1 + (((c0 << 4) + k2) ^ (c0 + cs) ^ ((c0 >> 5) + k3));
      end else begin
        c1 = c1 - (((c0 << 4) + k2) ^ (c0 + cs) ^ ((c0 >> 5) + k3));
        c0 = c0 - (((c1 << 4) + k0) ^ (c1 + cs) ^ ((c1 >> 5) + k1));
        cs = cs - DELTA;
      end
    end
  end

`ifdef TEA_CBC_EN
  logic [63:0] chain_q, cbc_xor_q, cbc_next_q, chain_cur;
  logic        cbc_on_q;

  // An iv_load on the accept edge takes precedence over the stored chain value.
  assign chain_cur = iv_load_i ? iv_i : chain_q;
  assign blk_in    = (chain_i && !mode_i) ? (block_i ^ chain_cur) : block_i;
  assign result    = (cbc_on_q && mode_q) ? ({c0, c1} ^ cbc_xor_q) : {c0, c1};

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      chain_q    <= 64'd0;
      cbc_xor_q  <= 64'd0;
      cbc_next_q <= 64'd0;
      cbc_on_q   <= 1'b0;
    end else if (state == IDLE) begin
      if (iv_load_i) chain_q <= iv_i;
      if (in_valid_i) begin
        cbc_on_q   <= chain_i;
        cbc_xor_q  <= chain_cur;
        cbc_next_q <= block_i;
      end
    end else if ((state == CALC) && last && cbc_on_q) begin
      chain_q <= mode_q ? cbc_next_q : result;
    end
  end
`else
  logic unused_cbc;
  assign unused_cbc = ^{iv_i, iv_load_i, chain_i};
  assign blk_in     = block_i;
  assign result     = {c0, c1};
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      int_o       <= 1'b0;
      block_o     <= 64'd0;
      v0_q        <= 32'd0;
      v1_q        <= 32'd0;
      sum_q       <= 32'd0;
      key_q       <= 128'd0;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      int_o <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            key_q      <= key_i;
            mode_q     <= mode_i;
            v0_q       <= blk_in[63:32];
            v1_q       <= blk_in[31:0];
            sum_q      <= mode_i ? SUM_DEC : 32'd0;
            cnt_q      <= '0;
            in_ready_o <= 1'b0;
            busy_o     <= 1'b1;
            state      <= CALC;
          end
        end
        CALC: begin
          v0_q  <= c0;
          v1_q  <= c1;
          sum_q <= cs;
          cnt_q <= cnt_nxt;
          if (last) begin
            block_o     <= result;
            out_valid_o <= 1'b1;
            int_o       <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          // in_ready_o only rises after the handshake edge, so no same-cycle restart.
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            in_ready_o  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
